// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed on-chip memory.
// One outstanding write and one outstanding read; AW and W accepted in either order.
module axi4_lite_slave_mem #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    ACLK,
    input  logic                    ARSTN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Out-of-window beats DECERR; misalignment inside the window is SLVERR.
    function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> OFF_W;
        if ((addr < BASE_ADDR) || (word >= ADDR_WIDTH'(DEPTH_WORDS)))
            return RESP_DECERR;
        else if (addr[OFF_W-1:0] != '0)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> OFF_W;
        return IDX_W'(word);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  ready_en_q;
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [STRB_W-1:0]     wr_strb_c;
    logic [1:0]            wr_resp_c, rd_resp_c;
    logic [IDX_W-1:0]      wr_idx_c;

    assign AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign ARREADY = ready_en_q & ~rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs_c   = AWVALID & AWREADY;
    assign w_hs_c    = WVALID & WREADY;
    assign ar_hs_c   = ARVALID & ARREADY;
    assign commit_c  = (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);
    assign wr_addr_c = aw_held_q ? awaddr_q : AWADDR;
    assign wr_data_c = w_held_q ? wdata_q : WDATA;
    assign wr_strb_c = w_held_q ? wstrb_q : WSTRB;
    assign wr_resp_c = decode(wr_addr_c);
    assign wr_idx_c  = word_idx(wr_addr_c);
    assign rd_resp_c = decode(ARADDR);

    // Write channel: hold whichever of AW/W arrives first, commit once both are present.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp_c;
        end else begin
            if (aw_hs_c) begin
                aw_held_d = 1'b1;
                awaddr_d  = AWADDR;
            end
            if (w_hs_c) begin
                w_held_d = 1'b1;
                wdata_d  = WDATA;
                wstrb_d  = WSTRB;
            end
        end
        if (bvalid_q && BREADY) bvalid_d = 1'b0;
    end

    // Read channel: the memory read sees pre-write contents on a same-edge commit.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_resp_c;
            rdata_d  = (rd_resp_c == RESP_OKAY) ? mem[word_idx(ARADDR)] : '0;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Storage survives reset; only an OKAY commit touches it.
    always_ff @(posedge ACLK) begin
        if (commit_c && (wr_resp_c == RESP_OKAY)) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wr_strb_c[i]) mem[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem: vector table plus multi-cycle corner sequences.
module tb_axi4_lite_slave_mem;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          ACLK = 1'b0;
    logic          ARSTN;
    logic          AWVALID, AWREADY;
    logic [AW-1:0] AWADDR;
    logic          WVALID, WREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          BVALID, BREADY;
    logic [1:0]    BRESP;
    logic          ARVALID, ARREADY;
    logic [AW-1:0] ARADDR;
    logic          RVALID, RREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    axi4_lite_slave_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .ACLK   (ACLK),
        .ARSTN  (ARSTN),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .AWADDR (AWADDR),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .BRESP  (BRESP),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .ARADDR (ARADDR),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int cnt;
        cnt = 0;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        while (!(AWREADY && WREADY) && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt >= 20) timeout("wr_ready");
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_bvalid_latency", 64'(BVALID), 64'd1);
        resp = BRESP;
        tick();
        chk("wr_bvalid_drop", 64'(BVALID), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] d);
        int cnt;
        cnt = 0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        while (!ARREADY && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt >= 20) timeout("rd_ready");
        tick();
        ARVALID = 1'b0;
        chk("rd_rvalid_latency", 64'(RVALID), 64'd1);
        resp = RRESP;
        d    = RDATA;
        tick();
        chk("rd_rvalid_drop", 64'(RVALID), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h14,   32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h14,   32'hAABBCCDD, 4'h6, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h14,   32'h0,        4'h0, 2'b00, 32'hCABBCC0D};
        vecs[5]  = '{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 32'h14,   32'h0,        4'h0, 2'b00, 32'hCABBCC0D};
        vecs[7]  = '{1'b1, 32'hFFC,  32'h12345678, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'hFFC,  32'h0,        4'h0, 2'b00, 32'h12345678};
        vecs[9]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 2'b11, 32'h0};
        vecs[10] = '{1'b0, 32'h1000, 32'h0,        4'h0, 2'b11, 32'h0};
        vecs[11] = '{1'b1, 32'h12,   32'h77777777, 4'hF, 2'b10, 32'h0};
        vecs[12] = '{1'b0, 32'h12,   32'h0,        4'h0, 2'b10, 32'h0};
        vecs[13] = '{1'b0, 32'h10,   32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 2'b00, 32'h12345678};

        ARSTN = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
        #3;
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_readys", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        tick();
        tick();
        ARSTN = 1'b1;
        #1;
        chk("post_rst_readys_low", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        tick();
        chk("post_rst_readys_high", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), 64'(r), 64'(vecs[i].resp));
            end else begin
                do_read(vecs[i].addr, r, d);
                chk($sformatf("vec%0d_rresp", i), 64'(r), 64'(vecs[i].resp));
                chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].rdata));
            end
        end

        // W three cycles ahead of AW: single commit on the AW edge
        BREADY = 1'b1;
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("wfirst_no_commit", 64'(BVALID), 64'd0);
            chk("wfirst_wready_low", 64'(WREADY), 64'd0);
            if (k < 2) tick();
        end
        AWADDR = 32'h10; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("wfirst_commit", 64'(BVALID), 64'd1);
        chk("wfirst_bresp", 64'(BRESP), 64'd0);
        tick();
        do_read(32'h10, r, d);
        chk("wfirst_rdata", 64'(d), 64'hDE22BE44);

        // BREADY held low: response stable, channels stalled
        BREADY = 1'b0;
        AWADDR = 32'h18; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        AWADDR = 32'h1C;
        for (int k = 0; k < 5; k++) begin
            chk("bhold_bvalid", 64'(BVALID), 64'd1);
            chk("bhold_bresp", 64'(BRESP), 64'd0);
            chk("bhold_readys", 64'({AWREADY, WREADY}), 64'd0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        chk("bhold_released", 64'(BVALID), 64'd0);
        chk("bhold_awready_back", 64'(AWREADY), 64'd1);
        tick();
        AWVALID = 1'b0;
        chk("bhold_aw_held", 64'(AWREADY), 64'd0);
        chk("bhold_no_early_commit", 64'(BVALID), 64'd0);
        WDATA = 32'h66666666; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("bhold_second_commit", 64'(BVALID), 64'd1);
        tick();
        do_read(32'h18, r, d);
        chk("bhold_rdata_18", 64'(d), 64'h5A5A5A5A);
        do_read(32'h1C, r, d);
        chk("bhold_rdata_1c", 64'(d), 64'h66666666);

        // Same-edge AR and write commit to one word, RREADY held low
        do_write(32'h20, 32'h01010101, 4'hF, r);
        ARADDR = 32'h20; ARVALID = 1'b1; RREADY = 1'b0;
        AWADDR = 32'h20; AWVALID = 1'b1; WDATA = 32'h02020202; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b1;
        tick();
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        chk("same_edge_bvalid", 64'(BVALID), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("same_edge_rvalid", 64'(RVALID), 64'd1);
            chk("same_edge_old_rdata", 64'(RDATA), 64'h01010101);
            chk("same_edge_rresp", 64'(RRESP), 64'd0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        chk("same_edge_rdone", 64'(RVALID), 64'd0);
        do_read(32'h20, r, d);
        chk("same_edge_new_rdata", 64'(d), 64'h02020202);

        // Reset with AW held and RVALID pending
        do_write(32'h24, 32'h0BADF00D, 4'hF, r);
        ARADDR = 32'h24; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        chk("mid_rst_rvalid_set", 64'(RVALID), 64'd1);
        AWADDR = 32'h24; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("mid_rst_aw_held", 64'(AWREADY), 64'd0);
        #3;
        ARSTN = 1'b0;
        #1;
        chk("mid_rst_rvalid_async", 64'(RVALID), 64'd0);
        chk("mid_rst_bvalid", 64'(BVALID), 64'd0);
        chk("mid_rst_rdata", 64'(RDATA), 64'd0);
        @(posedge ACLK);
        #1;
        ARSTN = 1'b1;
        #1;
        chk("mid_rst_readys_low", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        tick();
        chk("mid_rst_readys_high", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
        WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("mid_rst_aw_discarded", 64'(BVALID), 64'd0);
        do_read(32'h24, r, d);
        chk("mid_rst_mem_intact", 64'(d), 64'h0BADF00D);
        do_read(32'h10, r, d);
        chk("mem_survives_reset", 64'(d), 64'hDE22BE44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
